// File: rtl/wm_phase_timer_if.sv
// -----------------------------------------------------------------------------
// wm_phase_timer_if
// Signal bundle between the washing-machine controller side and the phase
// timer.
//
// Handshake semantics: there is no valid/ready pair. A request is a level
// change on 'start'. The timer accepts a cycle only on a rising edge of
// 'start' seen while it is idle and 'stop' is low. 'stop' is a level abort
// request that acts on the next clock edge. Every timer_* code is a
// registered level that holds until the next phase change. The controller's
// phase flags are sampled levels.
//
// Modports:
//   master : controller/user side. Drives start, select, stop and the phase
//            flags, and observes the timer outputs.
//   slave  : the phase timer itself.
//
// Parameters:
//   CNT_W  : width of the remain counter.
// -----------------------------------------------------------------------------
interface wm_phase_timer_if #(
  parameter int CNT_W = 16
);
  // user / shared control
  logic             start;
  logic             select;
  logic             stop;

  // controller phase flags (acknowledge inputs)
  logic             soak_low;
  logic             soak_high;
  logic             wash_low;
  logic             wash_high;
  logic             drain;
  logic             rinse;
  logic             spin;
  logic             idle;

  // timer codes to the controller
  logic             timer_soak_low;
  logic             timer_soak_high;
  logic             timer_wash_low;
  logic             timer_wash_high;
  logic             timer_drain;
  logic             timer_rinse;
  logic             timer_spin;

  // status
  logic [2:0]       phase;
  logic [CNT_W-1:0] remain;
  logic             busy;
  logic             cycle_done;
  logic             ack_err;

  modport master (
    output start, select, stop,
    output soak_low, soak_high, wash_low, wash_high, drain, rinse, spin, idle,
    input  timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
    input  timer_drain, timer_rinse, timer_spin,
    input  phase, remain, busy, cycle_done, ack_err
  );

  modport slave (
    input  start, select, stop,
    input  soak_low, soak_high, wash_low, wash_high, drain, rinse, spin, idle,
    output timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
    output timer_drain, timer_rinse, timer_spin,
    output phase, remain, busy, cycle_done, ack_err
  );
endinterface

// File: rtl/wm_phase_timer.sv
// -----------------------------------------------------------------------------
// wm_phase_timer
// Phase-duration timer and sequencer for the washing-machine controller.
// It walks IDLE -> SOAK -> WASH -> DRAIN -> RINSE -> SPIN -> IDLE, counts a
// programmable number of clk cycles per phase and issues the registered
// timer code the controller needs to advance to the next phase.
//
// Ports:
//   clk : clock
//   rst : asynchronous, active-low reset
//   bus : wm_phase_timer_if.slave
//         in  start, select, stop, soak_low..idle (controller phase flags)
//         out timer_soak_low..timer_spin, phase, remain, busy,
//             cycle_done, ack_err
//
// Optional build macro:
//   WM_ACK_CHECK_EN : when defined, every issued code arms an acknowledge
//                     counter. ack_err becomes sticky if the controller does
//                     not raise the matching phase flag within ACK_TIMEOUT
//                     cycles. When undefined, ack_err is tied to 0.
//
// Observability: 'phase' is the FSM state register itself, exported as-is.
// -----------------------------------------------------------------------------
module wm_phase_timer #(
  parameter int          CNT_W       = 16,
  parameter int unsigned T_SOAK_LOW  = 8,
  parameter int unsigned T_SOAK_HIGH = 12,
  parameter int unsigned T_WASH_LOW  = 10,
  parameter int unsigned T_WASH_HIGH = 16,
  parameter int unsigned T_DRAIN     = 6,
  parameter int unsigned T_RINSE     = 8,
  parameter int unsigned T_SPIN      = 10,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wm_phase_timer_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // FSM state encoding (also the value presented on 'phase')
  // ---------------------------------------------------------------------------
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SOAK  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_RINSE = 3'd4;
  localparam logic [2:0] PH_SPIN  = 3'd5;

  // Timer code bit positions inside code_q
  localparam logic [6:0] C_NONE      = 7'b000_0000;
  localparam logic [6:0] C_SOAK_LOW  = 7'b000_0001;
  localparam logic [6:0] C_SOAK_HIGH = 7'b000_0010;
  localparam logic [6:0] C_WASH_LOW  = 7'b000_0100;
  localparam logic [6:0] C_WASH_HIGH = 7'b000_1000;
  localparam logic [6:0] C_DRAIN     = 7'b001_0000;
  localparam logic [6:0] C_RINSE     = 7'b010_0000;
  localparam logic [6:0] C_SPIN      = 7'b100_0000;

  // A duration of N issues the next code N cycles after this one, so the
  // counter is loaded with N-1 and the phase expires when it reads 0.
  // N = 0 behaves as N = 1.
  function automatic logic [CNT_W-1:0] load_of(input int unsigned n);
    if (n == 0) return '0;
    return CNT_W'(n - 1);
  endfunction

  localparam logic [CNT_W-1:0] L_SOAK_LOW  = load_of(T_SOAK_LOW);
  localparam logic [CNT_W-1:0] L_SOAK_HIGH = load_of(T_SOAK_HIGH);
  localparam logic [CNT_W-1:0] L_WASH_LOW  = load_of(T_WASH_LOW);
  localparam logic [CNT_W-1:0] L_WASH_HIGH = load_of(T_WASH_HIGH);
  localparam logic [CNT_W-1:0] L_DRAIN     = load_of(T_DRAIN);
  localparam logic [CNT_W-1:0] L_RINSE     = load_of(T_RINSE);
  localparam logic [CNT_W-1:0] L_SPIN      = load_of(T_SPIN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             start_q;
  logic             sel;
  logic [2:0]       phase_q;
  logic [CNT_W-1:0] remain_q;
  logic [6:0]       code_q;
  logic             done_q;

  logic             sel_n;
  logic [2:0]       phase_n;
  logic [CNT_W-1:0] remain_n;
  logic [6:0]       code_n;
  logic             done_n;

  logic             start_edge;
  logic             in_cycle;
  logic             expire;
  logic             abort;
  logic             issue;

  assign start_edge = bus.start & ~start_q;
  assign in_cycle   = (phase_q != PH_IDLE);
  assign expire     = in_cycle && (remain_q == '0);
  // stop beats both expiry and a start edge; in IDLE it only blocks a start.
  assign abort      = bus.stop & in_cycle;
  assign issue      = ~bus.stop & ((~in_cycle & start_edge) | expire);

  always_comb begin
    sel_n    = sel;
    phase_n  = phase_q;
    remain_n = remain_q;
    code_n   = code_q;
    done_n   = 1'b0;

    if (abort) begin
      phase_n  = PH_IDLE;
      remain_n = '0;
      code_n   = C_NONE;
    end else if (issue) begin
      case (phase_q)
        PH_IDLE: begin
          // select is captured only here; later changes are ignored.
          sel_n    = bus.select;
          phase_n  = PH_SOAK;
          remain_n = bus.select ? L_SOAK_HIGH : L_SOAK_LOW;
          code_n   = bus.select ? C_SOAK_HIGH : C_SOAK_LOW;
        end
        PH_SOAK: begin
          phase_n  = PH_WASH;
          remain_n = sel ? L_WASH_HIGH : L_WASH_LOW;
          code_n   = sel ? C_WASH_HIGH : C_WASH_LOW;
        end
        PH_WASH: begin
          phase_n  = PH_DRAIN;
          remain_n = L_DRAIN;
          code_n   = C_DRAIN;
        end
        PH_DRAIN: begin
          phase_n  = PH_RINSE;
          remain_n = L_RINSE;
          code_n   = C_DRAIN | C_RINSE;
        end
        PH_RINSE: begin
          phase_n  = PH_SPIN;
          remain_n = L_SPIN;
          code_n   = C_DRAIN | C_SPIN;
        end
        PH_SPIN: begin
          phase_n  = PH_IDLE;
          remain_n = '0;
          code_n   = C_NONE;
          done_n   = 1'b1;
        end
        default: begin
          // Unused encodings fall back to IDLE quietly.
          phase_n  = PH_IDLE;
          remain_n = '0;
          code_n   = C_NONE;
        end
      endcase
    end else if (in_cycle) begin
      // Not expired, so remain_q is non-zero here and cannot underflow.
      remain_n = remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      sel      <= 1'b0;
      phase_q  <= PH_IDLE;
      remain_q <= '0;
      code_q   <= C_NONE;
      done_q   <= 1'b0;
    end else begin
      start_q  <= bus.start;
      sel      <= sel_n;
      phase_q  <= phase_n;
      remain_q <= remain_n;
      code_q   <= code_n;
      done_q   <= done_n;
    end
  end

  assign bus.timer_soak_low  = code_q[0];
  assign bus.timer_soak_high = code_q[1];
  assign bus.timer_wash_low  = code_q[2];
  assign bus.timer_wash_high = code_q[3];
  assign bus.timer_drain     = code_q[4];
  assign bus.timer_rinse     = code_q[5];
  assign bus.timer_spin      = code_q[6];
  assign bus.phase           = phase_q;
  assign bus.remain          = remain_q;
  assign bus.busy            = in_cycle;
  assign bus.cycle_done      = done_q;

  // ---------------------------------------------------------------------------
  // Optional acknowledge checker
  // ---------------------------------------------------------------------------
`ifdef WM_ACK_CHECK_EN
  // Identifiers for the controller flag expected after each issued code.
  localparam logic [2:0] F_IDLE      = 3'd0;
  localparam logic [2:0] F_SOAK_LOW  = 3'd1;
  localparam logic [2:0] F_SOAK_HIGH = 3'd2;
  localparam logic [2:0] F_WASH_LOW  = 3'd3;
  localparam logic [2:0] F_WASH_HIGH = 3'd4;
  localparam logic [2:0] F_DRAIN     = 3'd5;
  localparam logic [2:0] F_RINSE     = 3'd6;
  localparam logic [2:0] F_SPIN      = 3'd7;

  localparam int ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic             ack_armed;
  logic [ACK_W-1:0] ack_cnt;
  logic [2:0]       ack_exp;
  logic             ack_err_q;
  logic [2:0]       exp_n;
  logic             flag_seen;

  // Flag the controller should raise once it has acted on the code that is
  // being issued from the current phase.
  always_comb begin
    exp_n = F_IDLE;
    case (phase_q)
      PH_IDLE:  exp_n = bus.select ? F_SOAK_HIGH : F_SOAK_LOW;
      PH_SOAK:  exp_n = sel ? F_WASH_HIGH : F_WASH_LOW;
      PH_WASH:  exp_n = F_DRAIN;
      PH_DRAIN: exp_n = F_RINSE;
      PH_RINSE: exp_n = F_SPIN;
      default:  exp_n = F_IDLE;
    endcase
  end

  always_comb begin
    flag_seen = 1'b0;
    case (ack_exp)
      F_IDLE:      flag_seen = bus.idle;
      F_SOAK_LOW:  flag_seen = bus.soak_low;
      F_SOAK_HIGH: flag_seen = bus.soak_high;
      F_WASH_LOW:  flag_seen = bus.wash_low;
      F_WASH_HIGH: flag_seen = bus.wash_high;
      F_DRAIN:     flag_seen = bus.drain;
      F_RINSE:     flag_seen = bus.rinse;
      F_SPIN:      flag_seen = bus.spin;
      default:     flag_seen = 1'b0;
    endcase
  end

  // A new issue re-arms and supersedes any check still pending from the
  // previous code. The check starts the cycle after the issue, so a flag
  // present on the issuing edge itself is not taken as an acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_armed <= 1'b0;
      ack_cnt   <= '0;
      ack_exp   <= F_IDLE;
      ack_err_q <= 1'b0;
    end else if (bus.stop) begin
      ack_armed <= 1'b0;
    end else if (issue) begin
      ack_armed <= 1'b1;
      ack_cnt   <= ACK_W'(ACK_TIMEOUT);
      ack_exp   <= exp_n;
      // An accepted start edge clears the sticky error.
      if (!in_cycle) ack_err_q <= 1'b0;
    end else if (ack_armed) begin
      if (flag_seen) begin
        ack_armed <= 1'b0;
      end else if (ack_cnt <= ACK_W'(1)) begin
        ack_armed <= 1'b0;
        ack_err_q <= 1'b1;
      end else begin
        ack_cnt <= ack_cnt - ACK_W'(1);
      end
    end
  end

  assign bus.ack_err = ack_err_q;
`else
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;
  logic unused_flags;
  assign unused_flags = ^{bus.soak_low, bus.soak_high, bus.wash_low,
                          bus.wash_high, bus.drain, bus.rinse, bus.spin,
                          bus.idle};
  assign bus.ack_err  = 1'b0;
`endif

endmodule
